registro_pipe_vec: RTL and testbench
====================================

REGISTRO_PIPE_VEC -- requirements
Module: registro_pipe_vec

Interface
REQ-001 Parameter LANES, default 4, vector lanes per operand.
REQ-002 Parameter LANE_W, default 8, bits per lane.
REQ-003 Parameter NVEC, default 3, vector operands carried (VEC1, VEC2, VFS order, lowest index at LSB).
REQ-004 Parameter SCA_W, default 8, scalar/immediate field width.
REQ-005 Parameter CTRL_W, default 16, packed EXE/MEM/WB control bits; every bit is active-high.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 flush  in  1  discard stage contents and insert bubble.
REQ-009 in_valid  in  1  upstream word present.
REQ-010 in_ready  out  1  stage accepts word this cycle.
REQ-011 in_ctrl  in  CTRL_W  control bits.
REQ-012 in_vec  in  NVEC*LANES*LANE_W  packed vector operands.
REQ-013 in_sca  in  SCA_W  scalar/immediate.
REQ-014 out_valid  out  1  stage holds valid word.
REQ-015 out_ready  in  1  downstream accepts word.
REQ-016 out_ctrl, out_vec, out_sca  out  CTRL_W, NVEC*LANES*LANE_W, SCA_W  registered payload.
REQ-017 stall_cnt  out  16  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Transfer in: in_valid && in_ready at rising edge; transfer out: out_valid && out_ready at rising edge.
REQ-019 Latency 1 cycle: word accepted at edge N appears on outputs after edge N when stage was empty or draining.
REQ-020 Words leave in acceptance order; none lost, none duplicated.
REQ-021 Payload registers load only on transfer in; otherwise hold value.
REQ-022 out_ctrl SHALL read all-zero whenever out_valid=0, so bubbles never assert mem_wr/reg_wr.
REQ-023 in_ready SHALL be 0 whenever flush=1.
REQ-024 flush=1 at edge: out_valid<=0, skid entry (if present) invalidated, input not captured; flush wins over simultaneous transfer in/out.
REQ-025 Full stage with out_ready=0: out_valid and payload hold stable until out_ready=1.
REQ-026 stall_cnt increments at each edge with out_valid && !out_ready && !flush; saturates at 0xFFFF; no wrap.
REQ-027 Simultaneous transfer out and transfer in on a full single-entry stage: new word replaces old at same edge, out_valid stays 1.

Reset
REQ-028 rst_n=0 immediately forces out_valid=0, out_ctrl=0, out_vec=0, out_sca=0, stall_cnt=0, skid empty, independent of clk.
REQ-029 Reset mid-transfer discards all held words; first edge after rst_n deasserts behaves as empty stage.
REQ-030 in_ready=0 while rst_n=0.

Configuration
REQ-031 Macro REG_PIPE_SKID_EN compiled out: single entry, in_ready = !flush && (!out_valid || out_ready), combinational.
REQ-032 REG_PIPE_SKID_EN defined: main plus one skid entry; in_ready = !flush && skid empty, driven from a register with no combinational path from out_ready.
REQ-033 Skid mode: word accepted while main full and out_ready=0 goes to skid; on next transfer out, skid moves to main; full throughput with out_ready=1 continuously.
REQ-034 Both builds SHALL produce identical output word sequences for identical accepted input.

Verification
REQ-035 Streaming: in_valid=1, out_ready=1, in_sca=1..8 on consecutive edges -> out_sca 1..8 one cycle later, out_valid=1 continuously, stall_cnt=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles holding word sca=0x2A -> out_sca=0x2A stable, stall_cnt=5, no word loss after release (skid build: exactly one extra word buffered).
REQ-037 Flush with in_valid=1, in_ctrl=0xFFFF -> out_valid=0, out_ctrl=0x0000 next cycle, input word never appears.
REQ-038 Async reset: rst_n low between edges with out_valid=1 -> outputs zero immediately, stall_cnt=0, next accepted word emerges after 1 cycle.
REQ-039 Saturation: out_ready=0 held 70000 cycles with out_valid=1 -> stall_cnt=0xFFFF, holds.
REQ-040 Parameter sweep LANES=8, LANE_W=16, NVEC=2: random valid/ready traffic -> scoreboard match, in both REG_PIPE_SKID_EN builds.

Source files
------------

// File: rtl/registro_pipe_vec.sv
// Pipeline register for vector operands with valid/ready handshake.
// REG_PIPE_SKID_EN adds a skid entry and a registered in_ready.
module registro_pipe_vec #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int NVEC   = 3,
    parameter int SCA_W  = 8,
    parameter int CTRL_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CTRL_W-1:0]             in_ctrl,
    input  logic [NVEC*LANES*LANE_W-1:0]  in_vec,
    input  logic [SCA_W-1:0]              in_sca,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CTRL_W-1:0]             out_ctrl,
    output logic [NVEC*LANES*LANE_W-1:0]  out_vec,
    output logic [SCA_W-1:0]              out_sca,
    output logic [15:0]                   stall_cnt
);
    localparam int VEC_W = NVEC * LANES * LANE_W;

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [SCA_W-1:0]  sca_q, sca_d;
    logic [15:0]       stall_q, stall_d;
    logic              take;
    logic              pop;

    assign take = in_valid && in_ready;
    assign pop  = valid_q && out_ready;

`ifdef REG_PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [VEC_W-1:0]  skid_vec_q, skid_vec_d;
    logic [SCA_W-1:0]  skid_sca_q, skid_sca_d;

    // Only registered state and flush reach in_ready; out_ready does not.
    assign in_ready = rst_n && !flush && !skid_valid_q;

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        vec_d        = vec_q;
        sca_d        = sca_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_vec_d   = skid_vec_q;
        skid_sca_d   = skid_sca_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!valid_q || pop) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                vec_d        = skid_vec_q;
                sca_d        = skid_sca_q;
                skid_valid_d = 1'b0;
            end else if (take) begin
                valid_d = 1'b1;
                ctrl_d  = in_ctrl;
                vec_d   = in_vec;
                sca_d   = in_sca;
            end else begin
                valid_d = 1'b0;
            end
        end else if (take) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_vec_d   = in_vec;
            skid_sca_d   = in_sca;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_vec_q   <= '0;
            skid_sca_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_vec_q   <= skid_vec_d;
            skid_sca_q   <= skid_sca_d;
        end
    end
`else
    assign in_ready = rst_n && !flush && (!valid_q || out_ready);

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        vec_d   = vec_q;
        sca_d   = sca_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (take) begin
            valid_d = 1'b1;
            ctrl_d  = in_ctrl;
            vec_d   = in_vec;
            sca_d   = in_sca;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end
`endif

    always_comb begin
        stall_d = stall_q;
        if (valid_q && !out_ready && !flush && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            vec_q   <= '0;
            sca_q   <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            vec_q   <= vec_d;
            sca_q   <= sca_d;
            stall_q <= stall_d;
        end
    end

    // Bubbles must never carry live control bits downstream.
    assign out_valid = valid_q;
    assign out_ctrl  = valid_q ? ctrl_q : '0;
    assign out_vec   = vec_q;
    assign out_sca   = sca_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_registro_pipe_vec.sv
// Bench for registro_pipe_vec: default and LANES=8/LANE_W=16/NVEC=2 instances.
// Queue-based reference model of accepted words.
module tb_registro_pipe_vec;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [15:0]  in_ctrl;
    logic [7:0]   in_sca;
    logic [95:0]  in_vec;
    logic [255:0] in_vec2;

    logic         in_ready, out_valid;
    logic [15:0]  out_ctrl, stall_cnt;
    logic [95:0]  out_vec;
    logic [7:0]   out_sca;

    logic         in_ready2, out_valid2;
    logic [15:0]  out_ctrl2, stall_cnt2;
    logic [255:0] out_vec2;
    logic [7:0]   out_sca2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0]  ctrl;
        logic [7:0]   sca;
        logic [95:0]  vec;
        logic [255:0] vec2;
    } word_t;

    word_t q[$];
    int    stall_m = 0;

    always #5 clk = ~clk;

    registro_pipe_vec u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_vec(in_vec), .in_sca(in_sca),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_vec(out_vec), .out_sca(out_sca),
        .stall_cnt(stall_cnt)
    );

    registro_pipe_vec #(.LANES(8), .LANE_W(16), .NVEC(2)) u_sw (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_ctrl(in_ctrl), .in_vec(in_vec2), .in_sca(in_sca),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_ctrl(out_ctrl2), .out_vec(out_vec2), .out_sca(out_sca2),
        .stall_cnt(stall_cnt2)
    );

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit can_accept(input bit rdy);
`ifdef REG_PIPE_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || rdy;
`endif
    endfunction

    task automatic check_outputs();
        bit v;
        v = q.size() > 0;
        check("out_valid", out_valid, v);
        check("out_valid_sw", out_valid2, v);
        check("out_ctrl", out_ctrl, v ? q[0].ctrl : 16'h0);
        check("out_ctrl_sw", out_ctrl2, v ? q[0].ctrl : 16'h0);
        check("stall_cnt", stall_cnt, stall_m);
        check("stall_cnt_sw", stall_cnt2, stall_m);
        if (v) begin
            check("out_sca", out_sca, q[0].sca);
            check("out_vec", out_vec, q[0].vec);
            check("out_sca_sw", out_sca2, q[0].sca);
            check("out_vec_sw", out_vec2, q[0].vec2);
        end
    endtask

    task automatic step(input bit v, input bit rdy, input bit fl,
                        input logic [15:0] c, input logic [7:0] s);
        word_t w;
        bit    er;
        bit    tk;
        bit    held;
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
        in_ctrl   = c;
        in_sca    = s;
        in_vec    = {$urandom, $urandom, $urandom};
        in_vec2   = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
        w.ctrl = c;
        w.sca  = s;
        w.vec  = in_vec;
        w.vec2 = in_vec2;
        #1;
        er = !fl && can_accept(rdy);
        check("in_ready", in_ready, er);
        check("in_ready_sw", in_ready2, er);
        tk = v && er;
        held = q.size() > 0;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (held && !rdy && stall_m < 65535) stall_m++;
            if (held && rdy) void'(q.pop_front());
            if (tk) q.push_back(w);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_ctrl = '0;
        in_sca = '0;
        in_vec = '0;
        in_vec2 = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_vec", out_vec, 0);
        check("rst_out_sca", out_sca, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 0, 16'($urandom), 8'(i));
            check("stream_sca", out_sca, i);
            check("stream_valid", out_valid, 1);
        end
        check("stream_stall", stall_cnt, 0);

        step(1, 1, 0, 16'h00A5, 8'h2A);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 16'($urandom), 8'(8'h30 + i));
            check("bp_sca_hold", out_sca, 8'h2A);
        end
        check("bp_stall5", stall_cnt, 5);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0, 8'h0);
        check("bp_drained", out_valid, 0);

        step(1, 1, 0, 16'h1234, 8'h55);
        step(1, 1, 1, 16'hFFFF, 8'hEE);
        check("flush_valid", out_valid, 0);
        check("flush_ctrl", out_ctrl, 0);
        step(0, 1, 0, 16'h0, 8'h0);
        check("flush_gone", out_valid, 0);

        step(1, 0, 0, 16'hBEEF, 8'h77);
        step(1, 0, 0, 16'hCAFE, 8'h78);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ctrl", out_ctrl, 0);
        check("arst_vec", out_vec, 0);
        check("arst_sca", out_sca, 0);
        check("arst_stall", stall_cnt, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_vec_sw", out_vec2, 0);
        q.delete();
        stall_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 16'h0F0F, 8'h99);
        check("arst_first_valid", out_valid, 1);
        check("arst_first_sca", out_sca, 8'h99);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0,
                 ($urandom % 24) == 0, 16'($urandom), 8'($urandom));
        end

        step(1, 1, 0, 16'h0001, 8'h11);
        for (int i = 0; i < 70000; i++) step(0, 0, 0, 16'h0, 8'h0);
        check("sat_stall", stall_cnt, 16'hFFFF);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 8'h0);
        check("sat_hold", stall_cnt, 16'hFFFF);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0, 8'h0);
        check("sat_drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
